// File: rtl/fir_stream_source_if.sv
// AXI-Stream beat bundle carrying ADC samples into the FIR slave input.
// The master drives data/qualifiers; the slave returns tready.
interface fir_stream_source_if #(
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/fir_stream_source.sv
// ADC sample strobe -> FIFO -> registered AXI-Stream output framed into FRAME_LEN packets.
// Disabling drains the FIFO and zero-pads the open frame up to its tlast beat.
module fir_stream_source #(
  parameter int DATA_WIDTH = 16,
  parameter int KEEP_WIDTH = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [DATA_WIDTH-1:0]         adc_data_i,
  input  logic                          adc_valid_i,
  fir_stream_source_if.master           m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [CNT_WIDTH-1:0]          overflow_cnt_o,
  output logic [CNT_WIDTH-1:0]          frame_cnt_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;

  logic                  out_valid, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IW-1:0]         load_idx;

  logic fifo_empty, fifo_full, out_free, fire;
  logic pop, pad, load, push, drop;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LEVEL);
  assign out_free   = !out_valid || m_axis.tready;
  assign fire       = out_valid && m_axis.tready;

  // load_idx tracks the frame position of the next beat entering the output
  // register; loads happen in stream order so it equals the transfer index.
  assign pop  = !fifo_empty && out_free;
  assign pad  = (state_q == ST_FLUSH) && fifo_empty && out_free && (load_idx != '0);
  assign load = pop || pad;
  assign push = (state_q == ST_RUN) && adc_valid_i && (!fifo_full || pop);
  assign drop = (state_q == ST_RUN) && adc_valid_i && !push;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i) begin
          // Skip FLUSH when nothing is left and no frame is open after this edge.
          if (fifo_empty && !push &&
              ((!out_valid && load_idx == '0) || (fire && out_last)))
            state_d = ST_IDLE;
          else
            state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty &&
            ((fire && out_last) || (!out_valid && load_idx == '0)))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= adc_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_data       <= '0;
      load_idx       <= '0;
      overflow_cnt_o <= '0;
      frame_cnt_o    <= '0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= pop ? mem[rd_ptr] : '0;
        out_last  <= (load_idx == LAST_IDX);
      end else if (fire) begin
        out_valid <= 1'b0;
      end

      if (state_q == ST_IDLE)
        load_idx <= '0;
      else if (load)
        load_idx <= (load_idx == LAST_IDX) ? '0 : load_idx + IW'(1);

      if (drop && overflow_cnt_o != '1)
        overflow_cnt_o <= overflow_cnt_o + CNT_WIDTH'(1);

      if (fire && out_last)
        frame_cnt_o <= frame_cnt_o + CNT_WIDTH'(1);
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = {KEEP_WIDTH{1'b1}};
  assign m_axis.tlast  = out_last;
  assign m_axis.tvalid = out_valid;
  assign fifo_level_o  = level;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_stream_source.sv
// Directed bench for fir_stream_source: a queue-based stream model checked every
// cycle, plus literal expectations for the individual scenarios.
module tb_fir_stream_source;
  localparam int DW = 16;
  localparam int KW = 4;
  localparam int D  = 4;
  localparam int F  = 8;
  localparam int CW = 16;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FLUSH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, enable, adc_valid, tready;
  logic [DW-1:0] adc_data;
  logic [$clog2(D):0] fifo_level;
  logic [CW-1:0] overflow_cnt, frame_cnt;
  logic          busy;

  fir_stream_source_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) axis ();
  assign axis.tready = tready;

  fir_stream_source #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FIFO_DEPTH(D), .FRAME_LEN(F), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .adc_data_i(adc_data),
    .adc_valid_i(adc_valid), .m_axis(axis), .fifo_level_o(fifo_level),
    .overflow_cnt_o(overflow_cnt), .frame_cnt_o(frame_cnt), .busy_o(busy)
  );

  // Narrow-counter instance for saturation.
  logic          enable_s, adc_valid_s, tready_s;
  logic [DW-1:0] adc_data_s;
  logic [$clog2(D):0] level_s;
  logic [3:0]    ovf_s, frame_s;
  logic          busy_s;

  fir_stream_source_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) axis_s ();
  assign axis_s.tready = tready_s;

  fir_stream_source #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FIFO_DEPTH(D), .FRAME_LEN(F), .CNT_WIDTH(4)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .enable_i(enable_s), .adc_data_i(adc_data_s),
    .adc_valid_i(adc_valid_s), .m_axis(axis_s), .fifo_level_o(level_s),
    .overflow_cnt_o(ovf_s), .frame_cnt_o(frame_s), .busy_o(busy_s)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stream model: every accepted sample or pad beat is queued with its tlast flag.
  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  beat_t exp_q[$];
  int    mode    = M_IDLE;
  int    acc_idx = 0;
  int    m_ovf   = 0;
  int    m_frames = 0;
  logic  hold_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic  hold_last;
  logic [DW-1:0] log_data[$];
  logic  log_last[$];

  always @(negedge clk) begin
    int    held0;
    beat_t b;
    if (rst) begin
      exp_q.delete();
      log_data.delete();
      log_last.delete();
      mode = M_IDLE; acc_idx = 0; m_ovf = 0; m_frames = 0; hold_prev = 1'b0;
    end else begin
      check("busy", busy, mode != M_IDLE);
      check("overflow_cnt", overflow_cnt, m_ovf);
      check("frame_cnt", frame_cnt, m_frames);
      check("tkeep", axis.tkeep, 4'hF);
      if (exp_q.size() == 0) check("tvalid_empty", axis.tvalid, 0);
      if (hold_prev) begin
        check("hold_tvalid", axis.tvalid, 1);
        check("hold_tdata", axis.tdata, hold_data);
        check("hold_tlast", axis.tlast, hold_last);
      end

      held0 = exp_q.size();
      if (axis.tvalid && tready) begin
        log_data.push_back(axis.tdata);
        log_last.push_back(axis.tlast);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("beat_tdata", axis.tdata, b.d);
          check("beat_tlast", axis.tlast, b.l);
          if (b.l) m_frames++;
        end
      end
      hold_prev = axis.tvalid && !tready;
      hold_data = axis.tdata;
      hold_last = axis.tlast;

      case (mode)
        M_IDLE: if (enable) begin mode = M_RUN; acc_idx = 0; end
        M_RUN: begin
          if (adc_valid) begin
            if (held0 <= D || tready) begin
              exp_q.push_back('{d: adc_data, l: (acc_idx == F-1)});
              acc_idx = (acc_idx + 1) % F;
            end else if (m_ovf < 65535) begin
              m_ovf++;
            end
          end
          if (!enable) begin
            if (exp_q.size() == 0 && acc_idx == 0) mode = M_IDLE;
            else begin
              mode = M_FLUSH;
              while (acc_idx != 0) begin
                exp_q.push_back('{d: '0, l: (acc_idx == F-1)});
                acc_idx = (acc_idx + 1) % F;
              end
            end
          end
        end
        M_FLUSH: if (exp_q.size() == 0) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; adc_valid = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      adc_data = DW'(i + 1); adc_valid = 1'b1;
      step(1);
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int b = budget;
    while (log_data.size() < n && b > 0) begin step(1); b--; end
    check("wait_log", log_data.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int b = budget;
    while (busy && b > 0) begin step(1); b--; end
    check("wait_idle", busy, 0);
  endtask

  int exp3 [8] = '{1, 2, 3, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0; tready = 1'b0;
    enable_s = 1'b0; adc_valid_s = 1'b0; adc_data_s = '0; tready_s = 1'b0;
    step(2);
    rst = 1'b0;

    // 1: full throughput, two frames
    enable = 1'b1; tready = 1'b1;
    step(1);
    for (int i = 0; i < 16; i++) begin
      adc_data = DW'(i + 1); adc_valid = 1'b1;
      step(1);
      if (i == 0) begin
        check("t1_first_tvalid_low", axis.tvalid, 0);
        check("t1_level_one", fifo_level, 1);
      end
      if (i == 1) begin
        check("t1_first_tvalid", axis.tvalid, 1);
        check("t1_first_tdata", axis.tdata, 1);
      end
    end
    adc_valid = 1'b0;
    wait_log(16, 20);
    check("t1_frame_cnt", frame_cnt, 2);
    check("t1_overflow", overflow_cnt, 0);
    for (int k = 0; k < 16 && k < log_data.size(); k++) begin
      check("t1_data", log_data[k], k + 1);
      check("t1_last", log_last[k], (k % 8) == 7);
    end

    // 2: backpressure and overflow
    do_reset();
    step(1);
    tready = 1'b0;
    push_seq(10);
    check("t2_overflow", overflow_cnt, 5);
    check("t2_level", fifo_level, 4);
    check("t2_tvalid", axis.tvalid, 1);
    check("t2_tdata", axis.tdata, 1);
    step(3);
    check("t2_tdata_held", axis.tdata, 1);
    tready = 1'b1;
    wait_log(5, 20);
    step(2);
    check("t2_count", log_data.size(), 5);
    for (int k = 0; k < 5 && k < log_data.size(); k++) check("t2_data", log_data[k], k + 1);
    check("t2_level_drained", fifo_level, 0);

    // 3: flush with zero padding
    do_reset();
    step(1);
    push_seq(3);
    enable = 1'b0;
    wait_idle(30);
    check("t3_count", log_data.size(), 8);
    for (int k = 0; k < 8 && k < log_data.size(); k++) begin
      check("t3_data", log_data[k], exp3[k]);
      check("t3_last", log_last[k], k == 7);
    end
    check("t3_frame_cnt", frame_cnt, 1);

    // 4: enable drops on the tlast transfer
    do_reset();
    enable = 1'b1;
    step(1);
    push_seq(8);
    step(1);
    enable = 1'b0;
    step(1);
    check("t4_busy", busy, 0);
    check("t4_tvalid", axis.tvalid, 0);
    check("t4_count", log_data.size(), 8);
    check("t4_frame_cnt", frame_cnt, 1);
    step(2);
    check("t4_no_pad", log_data.size(), 8);

    // 5: reset mid-frame, then a fresh frame
    do_reset();
    enable = 1'b1;
    step(1);
    push_seq(6);
    wait_log(5, 20);
    rst = 1'b1;
    step(1);
    check("t5_tvalid", axis.tvalid, 0);
    check("t5_tlast", axis.tlast, 0);
    check("t5_tdata", axis.tdata, 0);
    check("t5_tkeep", axis.tkeep, 4'hF);
    check("t5_level", fifo_level, 0);
    check("t5_overflow", overflow_cnt, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    step(1);
    push_seq(8);
    wait_log(8, 20);
    if (log_data.size() >= 8) begin
      check("t5_last_8th", log_last[7], 1);
      check("t5_last_5th", log_last[4], 0);
      check("t5_data_8th", log_data[7], 8);
    end
    check("t5_frame_cnt_after", frame_cnt, 1);

    // 6: saturating overflow counter
    enable_s = 1'b1;
    step(1);
    for (int i = 1; i <= 40; i++) begin
      adc_data_s = DW'(i); adc_valid_s = 1'b1;
      step(1);
      if (i == 10) check("t6_ovf_10", ovf_s, 5);
      if (i == 20) check("t6_ovf_20", ovf_s, 15);
      if (i == 21) check("t6_ovf_21", ovf_s, 15);
    end
    adc_valid_s = 1'b0;
    step(1);
    check("t6_ovf_40", ovf_s, 15);
    check("t6_level", level_s, 4);
    check("t6_tdata", axis_s.tdata, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_stream_source.md
Name: fir_stream_source

Overview:
- AXI-Stream transmitter that feeds the FIR slave input (s_axis_fir_*) from a raw ADC sample strobe.
- Buffers samples in a small FIFO and frames them into fixed-length packets with tlast on the final sample.
- Honours downstream tready backpressure and counts samples dropped on overflow.
- On disable, drains the FIFO and zero-pads the open frame so the downstream FIR never sees a truncated packet.

Parameters:
- DATA_WIDTH, 16, ADC sample width and m_axis_tdata_o width.
- KEEP_WIDTH, 4, tkeep width; driven all ones.
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 4.
- FRAME_LEN, 1024, samples per packet; minimum 2.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk_i  in  1  single clock for the whole block.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  stream enable (level).
- adc_data_i  in  DATA_WIDTH  signed ADC sample.
- adc_valid_i  in  1  sample strobe, one sample per high cycle.
- m_axis_tdata_o  out  DATA_WIDTH  signed sample to FIR.
- m_axis_tkeep_o  out  KEEP_WIDTH  constant all ones.
- m_axis_tlast_o  out  1  high on the last sample of each frame.
- m_axis_tvalid_o  out  1  output beat valid.
- m_axis_tready_i  in  1  downstream ready.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_cnt_o  out  CNT_WIDTH  dropped samples; saturates at all ones.
- frame_cnt_o  out  CNT_WIDTH  completed frames (tlast handshakes); wraps.
- busy_o  out  1  high when state is not IDLE.

Behaviour:
Reset (rst_i=1 at a clock edge):
- State goes to IDLE and the FIFO empties.
- tvalid=0, tlast=0, tdata=0, tkeep=all ones.
- fifo_level, overflow_cnt and frame_cnt all reset to 0; busy=0.
- Reset mid-frame abandons the frame; no padding or tlast is emitted.

Handshake:
- A beat transfers on an edge where tvalid && tready.
- Once tvalid is high, tdata and tlast hold stable until the transfer.
- tvalid never depends combinationally on tready.
- Output is a registered stage after the FIFO (FWFT). Sample accepted at edge k into an empty FIFO/output stage → tvalid=1 after edge k+1.
- Full throughput is 1 beat/clk when tready is held high.

Sample accept:
- A sample is accepted only in RUN, when adc_valid_i=1 and there is space.
- Space exists if not full, or if full and a FIFO read happens on the same edge.
- Full with no read: the sample is dropped and overflow_cnt increments (saturating).
- adc_valid_i is ignored in IDLE and FLUSH; this does not count as overflow.

Frame counter:
- beat_idx counts 0..FRAME_LEN-1 on each output transfer and wraps after tlast.
- tlast=1 exactly when the presented beat has beat_idx==FRAME_LEN-1.
- frame_cnt increments on each tlast transfer.

State machine:
- IDLE: enable_i=1 → RUN. beat_idx=0.
- RUN: enable_i=0 → FLUSH. If beat_idx==0 and the FIFO and output stage are empty, go directly to IDLE instead.
- FLUSH: no new samples. Drain FIFO contents, then emit tdata=0 beats until the tlast beat transfers, then go to IDLE.
  - If the FIFO drains exactly at a frame boundary, no pad beats are emitted.
  - FIFO contents that span into a new frame are sent, and that frame is padded as well.
- enable_i returning high during FLUSH is ignored until IDLE is reached; RUN is re-entered on the following cycle.

Simultaneous events:
- Read and write on the same edge leave fifo_level unchanged.
- A tlast transfer coinciding with enable_i falling ends cleanly in IDLE with no pad beats.

Test Plan:
Bench settings: FIFO_DEPTH=4, FRAME_LEN=8.
1. Reset → enable=1, tready=1, adc_valid=1 with data 1..16 → 16 beats, tdata 1..16; tlast on beats 8 and 16; first tvalid one cycle after the first accept; frame_cnt=2; overflow_cnt=0.
2. Backpressure: tready=0 for 10 cycles while pushing 1..10 → values 1..5 retained (4 in FIFO + 1 in output reg); overflow_cnt=5; tdata=1 held stable; on release, beats 1..5 are sent in order.
3. Flush pad: push 1..3, then drop enable → beats 1,2,3,0,0,0,0,0 with tlast on the 8th; busy falls after the tlast transfer; frame_cnt=1.
4. Clean stop: push exactly 8 samples, drop enable on the tlast transfer cycle → no pad beats; IDLE next cycle.
5. Reset mid-frame after 5 beats → all outputs reach reset values the next cycle; re-enable and push 1..8 → tlast on the 8th beat (beat_idx restarted at 0).
6. Saturation: CNT_WIDTH=4, tready=0, 40 samples pushed → overflow_cnt=15 and stays there.
